// File: rtl/exec_sequencer_if.sv
// rtl/exec_sequencer_if.sv - control/status bundle between the sequencer and its datapath driver
interface exec_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [2:0]       inst_type;
    logic             mem_ack;
    logic             fetch_en;
    logic             decode_en;
    logic             reg_r_en;
    logic             alu_en;
    logic             reg_w_en;
    logic             reg_w_sel;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] inst_count;

    modport slave (
        input  start, inst_type, mem_ack,
        output fetch_en, decode_en, reg_r_en, alu_en, reg_w_en, reg_w_sel,
               mem_r_en, mem_w_en, busy, done, err, err_code, inst_count
    );

    modport master (
        output start, inst_type, mem_ack,
        input  fetch_en, decode_en, reg_r_en, alu_en, reg_w_en, reg_w_sel,
               mem_r_en, mem_w_en, busy, done, err, err_code, inst_count
    );
endinterface

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - multi-cycle instruction execution sequencer
module exec_sequencer #(
    parameter int CNT_W     = 16,
    parameter int MAX_WAIT  = 8,
    parameter int EX_CYCLES = 1
) (
    input logic             clk,
    input logic             init_n,
    exec_sequencer_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_OF, S_EX, S_WM, S_RM, S_RS, S_HALTED, S_ERROR
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
    localparam logic [3:0] EX_LAST   = 4'(EX_CYCLES - 1);
    localparam logic [2:0] T_ALU = 3'd1, T_JMPI = 3'd2, T_JMP = 3'd3, T_MOV = 3'd4,
                           T_ST  = 3'd5, T_LD   = 3'd6, T_HALT = 3'd7;

    state_t           state_q, state_d;
    logic [2:0]       type_q;
    logic [3:0]       ex_cnt_q;
    logic [7:0]       wait_cnt_q;
    logic [1:0]       err_code_q;
    logic [1:0]       err_set;
    logic [CNT_W-1:0] inst_count_q;
    logic             retire;
    logic             wait_expired;

    assign wait_expired = (wait_cnt_q == WAIT_LAST);

    // Next-state selection, retire pulse and error cause
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        err_set = 2'd0;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.inst_type)
                    T_ALU, T_JMP, T_ST, T_LD: state_d = S_OF;
                    T_JMPI: begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                    T_MOV:  state_d = S_RS;
                    T_HALT: begin
                        state_d = S_HALTED;
                        retire  = 1'b1;
                    end
                    default: begin
                        state_d = S_ERROR;
                        err_set = 2'd1;
                    end
                endcase
            end
            S_OF: begin
                case (type_q)
                    T_ALU: state_d = S_EX;
                    T_JMP: begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                    T_ST:  state_d = S_WM;
                    T_LD:  state_d = S_RM;
                    default: begin
                        state_d = S_ERROR;
                        err_set = 2'd1;
                    end
                endcase
            end
            S_EX:     if (ex_cnt_q == EX_LAST) state_d = S_RS;
            S_WM: begin
                // an acknowledge in the last wait cycle beats the timeout
                if (bus.mem_ack) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (wait_expired) begin
                    state_d = S_ERROR;
                    err_set = 2'd2;
                end
            end
            S_RM: begin
                if (bus.mem_ack) begin
                    state_d = S_RS;
                end else if (wait_expired) begin
                    state_d = S_ERROR;
                    err_set = 2'd2;
                end
            end
            S_RS: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALTED: if (bus.start) state_d = S_FETCH;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_IDLE;
        endcase
    end

    // State, latched type, phase counters, error cause and retire counter
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q      <= S_IDLE;
            type_q       <= 3'd0;
            ex_cnt_q     <= 4'd0;
            wait_cnt_q   <= 8'd0;
            err_code_q   <= 2'd0;
            inst_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) type_q <= bus.inst_type;
            // counters restart whenever their phase is (re)entered
            ex_cnt_q   <= (state_q == S_EX && state_d == S_EX) ? ex_cnt_q + 4'd1 : 4'd0;
            wait_cnt_q <= ((state_q == S_WM || state_q == S_RM) && state_d == state_q)
                          ? wait_cnt_q + 8'd1 : 8'd0;
            if (err_set != 2'd0) err_code_q <= err_set;
            if (retire && inst_count_q != {CNT_W{1'b1}}) inst_count_q <= inst_count_q + 1'b1;
        end
    end

    assign bus.fetch_en   = (state_q == S_FETCH);
    assign bus.decode_en  = (state_q == S_DECODE);
    assign bus.reg_r_en   = (state_q == S_OF);
    assign bus.alu_en     = (state_q == S_EX);
    assign bus.mem_w_en   = (state_q == S_WM);
    assign bus.mem_r_en   = (state_q == S_RM);
    assign bus.reg_w_en   = (state_q == S_RS);
    assign bus.reg_w_sel  = (state_q == S_RS) && (type_q == T_LD);
    assign bus.busy       = !(state_q == S_IDLE || state_q == S_HALTED || state_q == S_ERROR);
    assign bus.done       = (state_q == S_HALTED);
    assign bus.err        = (state_q == S_ERROR);
    assign bus.err_code   = err_code_q;
    assign bus.inst_count = inst_count_q;
endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - directed self-checking bench for exec_sequencer
module tb_exec_sequencer;
    logic clk = 1'b0;
    logic init_n;
    always #5 clk = ~clk;

    exec_sequencer_if #(.CNT_W(16)) bus ();
    exec_sequencer_if #(.CNT_W(2))  bus2 ();

    exec_sequencer #(.CNT_W(16), .MAX_WAIT(8), .EX_CYCLES(1)) dut (
        .clk(clk), .init_n(init_n), .bus(bus.slave)
    );
    exec_sequencer #(.CNT_W(2), .MAX_WAIT(8), .EX_CYCLES(1)) dut2 (
        .clk(clk), .init_n(init_n), .bus(bus2.slave)
    );

    // {fetch, decode, reg_r, alu, mem_w, mem_r, reg_w}
    localparam logic [6:0] E_NONE = 7'b0000000, E_F  = 7'b1000000, E_D  = 7'b0100000,
                           E_OF   = 7'b0010000, E_EX = 7'b0001000, E_WM = 7'b0000100,
                           E_RM   = 7'b0000010, E_RS = 7'b0000001;

    logic [6:0] en;
    assign en = {bus.fetch_en, bus.decode_en, bus.reg_r_en, bus.alu_en,
                 bus.mem_w_en, bus.mem_r_en, bus.reg_w_en};

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [6:0] exp_en);
        tick();
        check(tag, {25'b0, en}, {25'b0, exp_en});
    endtask

    task automatic check_status(input string tag, input logic b, input logic d, input logic e,
                                input logic [1:0] code, input logic [15:0] cnt);
        check({tag, "_busy"}, {31'b0, bus.busy}, {31'b0, b});
        check({tag, "_done"}, {31'b0, bus.done}, {31'b0, d});
        check({tag, "_err"},  {31'b0, bus.err},  {31'b0, e});
        check({tag, "_code"}, {30'b0, bus.err_code}, {30'b0, code});
        check({tag, "_cnt"},  {16'b0, bus.inst_count}, {16'b0, cnt});
    endtask

    initial begin
        init_n         = 1'b0;
        bus.start      = 1'b0;
        bus.inst_type  = 3'd0;
        bus.mem_ack    = 1'b0;
        bus2.start     = 1'b0;
        bus2.inst_type = 3'd4;
        bus2.mem_ack   = 1'b0;
        #2;
        check("rst_en", {25'b0, en}, 32'd0);
        check_status("rst", 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
        tick();
        init_n = 1'b1;
        step("idle", E_NONE);

        // MOV, ALU, HALT
        bus.start = 1'b1;
        step("mov_f", E_F);
        bus.start = 1'b0;
        bus.inst_type = 3'd4;
        step("mov_d", E_D);
        step("mov_rs", E_RS);
        check("mov_sel", {31'b0, bus.reg_w_sel}, 32'd0);
        bus.inst_type = 3'd1;
        step("alu_f", E_F);
        check("cnt1", {16'b0, bus.inst_count}, 32'd1);
        step("alu_d", E_D);
        step("alu_of", E_OF);
        step("alu_ex", E_EX);
        step("alu_rs", E_RS);
        check("alu_sel", {31'b0, bus.reg_w_sel}, 32'd0);
        bus.inst_type = 3'd7;
        step("halt_f", E_F);
        step("halt_d", E_D);
        step("halted", E_NONE);
        check_status("halted", 1'b0, 1'b1, 1'b0, 2'd0, 16'd3);

        // resume with LD, ack on third RM cycle
        bus.start = 1'b1;
        step("ld_f", E_F);
        bus.start = 1'b0;
        bus.inst_type = 3'd6;
        step("ld_d", E_D);
        check("resume_done", {31'b0, bus.done}, 32'd0);
        step("ld_of", E_OF);
        step("ld_rm1", E_RM);
        step("ld_rm2", E_RM);
        step("ld_rm3", E_RM);
        bus.mem_ack = 1'b1;
        step("ld_rs", E_RS);
        bus.mem_ack = 1'b0;
        check("ld_sel", {31'b0, bus.reg_w_sel}, 32'd1);
        // stray ack during FETCH must be ignored
        bus.mem_ack = 1'b1;
        bus.inst_type = 3'd5;
        step("st_f", E_F);
        check("cnt4", {16'b0, bus.inst_count}, 32'd4);
        bus.mem_ack = 1'b0;

        // ST with ack in the eighth wait cycle
        step("st_d", E_D);
        step("st_of", E_OF);
        for (int i = 0; i < 8; i++) step("st_wm", E_WM);
        bus.mem_ack = 1'b1;
        step("st_ack8_f", E_F);
        bus.mem_ack = 1'b0;
        check_status("st_ok", 1'b1, 1'b0, 1'b0, 2'd0, 16'd5);

        // ST without ack: timeout
        step("sto_d", E_D);
        step("sto_of", E_OF);
        for (int i = 0; i < 8; i++) step("sto_wm", E_WM);
        step("sto_err", E_NONE);
        check_status("timeout", 1'b0, 1'b0, 1'b1, 2'd2, 16'd5);
        bus.start = 1'b1;
        step("err_sticky", E_NONE);
        bus.start = 1'b0;
        check("err_sticky_err", {31'b0, bus.err}, 32'd1);

        // illegal type
        init_n = 1'b0;
        tick();
        init_n = 1'b1;
        bus.start = 1'b1;
        step("ill_f", E_F);
        bus.start = 1'b0;
        bus.inst_type = 3'd0;
        step("ill_d", E_D);
        step("ill_err", E_NONE);
        check_status("illegal", 1'b0, 1'b0, 1'b1, 2'd1, 16'd0);

        // reset mid-EX after one retire
        init_n = 1'b0;
        tick();
        init_n = 1'b1;
        bus.start = 1'b1;
        step("r_f", E_F);
        bus.start = 1'b0;
        bus.inst_type = 3'd4;
        step("r_d", E_D);
        step("r_rs", E_RS);
        bus.inst_type = 3'd1;
        step("r_f2", E_F);
        step("r_d2", E_D);
        step("r_of", E_OF);
        step("r_ex", E_EX);
        check("r_cnt_pre", {16'b0, bus.inst_count}, 32'd1);
        init_n = 1'b0;
        #1;
        check("async_en", {25'b0, en}, 32'd0);
        check_status("async", 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
        tick();
        init_n = 1'b1;

        // saturation with CNT_W=2
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        check("sat_f", {31'b0, bus2.fetch_en}, 32'd1);
        for (int i = 0; i < 9; i++) tick();
        check("sat_cnt3", {30'b0, bus2.inst_count}, 32'd3);
        for (int i = 0; i < 6; i++) tick();
        check("sat_cnt5", {30'b0, bus2.inst_count}, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
